// File: rtl/fma_dot_sequencer_if.sv
// ----------------------------------------------------------------------------
// fma_dot_sequencer_if
//
// Bundles every signal that crosses the boundary of the dot-product
// sequencer. There are three groups:
//   - the operand stream:  in_valid, in_ready, in_a, in_b, in_last
//   - the FMA datapath:    fma_a, fma_b, fma_c (to the FMA), fma_out (back)
//   - the result stream:   out_valid, out_ready, out_data, out_len, out_ovf
//
// Modports:
//   slave  - the sequencer itself
//   master - the environment around it: the operand producer, the FMA and
//            the result consumer
//
// CNT_W must match the CNT_W of the sequencer that is bound to it.
// ----------------------------------------------------------------------------
interface fma_dot_sequencer_if #(
    parameter int CNT_W = 9
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_last;

    logic [31:0]      fma_a;
    logic [31:0]      fma_b;
    logic [31:0]      fma_c;
    logic [31:0]      fma_out;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_len;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_last, fma_out, out_ready,
        output in_ready, fma_a, fma_b, fma_c, out_valid, out_data, out_len, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_last, fma_out, out_ready,
        input  in_ready, fma_a, fma_b, fma_c, out_valid, out_data, out_len, out_ovf
    );
endinterface

// File: rtl/fma_dot_sequencer.sv
// ----------------------------------------------------------------------------
// fma_dot_sequencer
//
// Streaming dot-product sequencer placed in front of a combinational
// single-precision FMA. Each accepted (a, b) pair is registered and, one
// cycle later, the FMA evaluates a*b + acc. Its result is written back into
// the accumulator. When the vector ends, the sum is held on the result port
// until the consumer accepts it. The ends of a vector are in_last or the
// MAX_LEN-th element. All 32-bit values are passed through as opaque bit
// patterns.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous, active-high reset
//   clear - synchronous abort; returns to ACCEPT and drops any partial sum
//   bus   - fma_dot_sequencer_if.slave: the operand stream, the FMA
//           connection and the result stream
//
// Throughput is one element every two cycles: ACCEPT, then EXEC.
// ----------------------------------------------------------------------------
module fma_dot_sequencer #(
    parameter int          MAX_LEN  = 256,
    parameter int          CNT_W    = 9,
    parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
    input logic                clk,
    input logic                rst,
    input logic                clear,
    fma_dot_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        EXEC   = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [31:0]        acc_q,    acc_d;
    logic [31:0]        opA_q,    opA_d;
    logic [31:0]        opB_q,    opB_d;
    logic               opLast_q, opLast_d;
    logic               inLast_q, inLast_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               ovf_q,    ovf_d;

    // The element accepted now is the MAX_LEN-th one, so it must end the vector.
    logic atLimit;
    assign atLimit = (cnt_q == CNT_W'(MAX_LEN - 1));

    // State and datapath registers. Reset drops everything at once, and no
    // state that drives out_valid survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ACCEPT;
            acc_q    <= ACC_INIT;
            opA_q    <= '0;
            opB_q    <= '0;
            opLast_q <= 1'b0;
            inLast_q <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            opLast_q <= opLast_d;
            inLast_q <= inLast_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state logic. clear is handled last so that it overrides any
    // handshake or result acceptance in the same cycle.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        opLast_d = opLast_q;
        inLast_d = inLast_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        case (state_q)
            ACCEPT: begin
                if (bus.in_valid) begin
                    opA_d    = bus.in_a;
                    opB_d    = bus.in_b;
                    inLast_d = bus.in_last;
                    opLast_d = bus.in_last | atLimit;
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                acc_d = bus.fma_out;
                if (opLast_q) begin
                    // Overflow means the limit ended the vector, not in_last.
                    ovf_d   = ~inLast_q;
                    state_d = DONE;
                end else begin
                    state_d = ACCEPT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    acc_d   = ACC_INIT;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCEPT;
                end
            end
            default: begin
                state_d = ACCEPT;
            end
        endcase

        if (clear) begin
            state_d  = ACCEPT;
            acc_d    = ACC_INIT;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            opA_d    = opA_q;
            opB_d    = opB_q;
            opLast_d = opLast_q;
            inLast_d = inLast_q;
        end
    end

    // Handshake outputs depend only on the state register.
    assign bus.in_ready  = (state_q == ACCEPT);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = acc_q;
    assign bus.out_len   = cnt_q;
    assign bus.out_ovf   = ovf_q;

    assign bus.fma_a = opA_q;
    assign bus.fma_b = opB_q;
    assign bus.fma_c = acc_q;

endmodule

// File: tb/tb_fma_dot_sequencer.sv
module tb_fma_dot_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic clear4;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [8:0]  len;
        logic        ovf;
    } res_t;

    res_t fpQ[$];
    res_t intQ[$];

    // fp32 <-> real for normal numbers and zero; the directed values are exact
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpFma(input logic [31:0] a, b, c);
        return r2f(f2r(a) * f2r(b) + f2r(c));
    endfunction

    fma_dot_sequencer_if #(.CNT_W(9)) fpIf ();
    fma_dot_sequencer_if #(.CNT_W(3)) intIf ();

    fma_dot_sequencer #(.MAX_LEN(256), .CNT_W(9), .ACC_INIT(32'h0)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (fpIf.slave)
    );

    fma_dot_sequencer #(.MAX_LEN(4), .CNT_W(3), .ACC_INIT(32'h0)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear4),
        .bus   (intIf.slave)
    );

    assign fpIf.fma_out  = fpFma(fpIf.fma_a, fpIf.fma_b, fpIf.fma_c);
    assign intIf.fma_out = intIf.fma_c + intIf.fma_a * intIf.fma_b;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one fp pair and returns just after its handshake edge (in EXEC)
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic last);
        bit hs = 1'b0;
        fpIf.in_valid = 1'b1;
        fpIf.in_a     = a;
        fpIf.in_b     = b;
        fpIf.in_last  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            hs = fpIf.in_valid && fpIf.in_ready;
            @(posedge clk);
            #1;
            if (hs) break;
        end
        fpIf.in_valid = 1'b0;
        if (!hs) checkOutput("fp_handshake_timeout", 64'(hs), 64'd1);
    endtask

    task automatic fpResult(input string tag);
        res_t e;
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (fpIf.out_valid) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        checkOutput({tag, "_valid"}, 64'(seen), 64'd1);
        if (fpQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 64'(fpQ.size()), 64'd1);
        end else begin
            e = fpQ.pop_front();
            checkOutput({tag, "_data"}, 64'(fpIf.out_data), 64'(e.data));
            checkOutput({tag, "_len"},  64'(fpIf.out_len),  64'(e.len));
            checkOutput({tag, "_ovf"},  64'(fpIf.out_ovf),  64'(e.ovf));
        end
    endtask

    // Reference model for the MAX_LEN=4 instance with the c + a*b stub FMA
    logic [31:0] mAcc = 32'd0;
    int          mCnt = 0;

    task automatic modelInt(input logic [31:0] a, input logic [31:0] b, input logic last);
        res_t r;
        mAcc = mAcc + a * b;
        mCnt++;
        if (last || mCnt == 4) begin
            r.data = mAcc;
            r.len  = 9'(mCnt);
            r.ovf  = !last;
            intQ.push_back(r);
            mAcc = 32'd0;
            mCnt = 0;
        end
    endtask

    task automatic applyInt(input logic [31:0] a, input logic [31:0] b, input logic last);
        bit hs = 1'b0;
        intIf.in_valid = 1'b1;
        intIf.in_a     = a;
        intIf.in_b     = b;
        intIf.in_last  = last;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            hs = intIf.in_valid && intIf.in_ready;
            if (hs) modelInt(a, b, last);
            @(posedge clk);
            #1;
            if (hs) break;
        end
        intIf.in_valid = 1'b0;
        if (!hs) checkOutput("int_handshake_timeout", 64'(hs), 64'd1);
    endtask

    // Result monitor and protocol checks for the MAX_LEN=4 instance
    bit hsPrev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            res_t e;
            if (hsPrev) checkOutput("int_in_ready_exec", 64'(intIf.in_ready), 64'd0);
            if (intIf.out_valid) checkOutput("int_in_ready_done", 64'(intIf.in_ready), 64'd0);
            if (intIf.out_valid && intIf.out_ready) begin
                if (intQ.size() == 0) begin
                    checkOutput("int_unexpected_result", 64'(intQ.size()), 64'd1);
                end else begin
                    e = intQ.pop_front();
                    checkOutput("int_data", 64'(intIf.out_data), 64'(e.data));
                    checkOutput("int_len",  64'(intIf.out_len),  64'(e.len));
                    checkOutput("int_ovf",  64'(intIf.out_ovf),  64'(e.ovf));
                end
            end
            hsPrev = intIf.in_valid && intIf.in_ready;
        end
    end

    task automatic drainInt(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (intQ.size() == 0) break;
            cyc();
        end
        checkOutput(tag, 64'(intQ.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    bit drvDone = 1'b0;

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        clear4 = 1'b0;
        fpIf.in_valid = 1'b0;  fpIf.in_a = '0;  fpIf.in_b = '0;  fpIf.in_last = 1'b0;
        fpIf.out_ready = 1'b0;
        intIf.in_valid = 1'b0; intIf.in_a = '0; intIf.in_b = '0; intIf.in_last = 1'b0;
        intIf.out_ready = 1'b1;
        cyc();
        cyc();

        checkOutput("rst_in_ready",  64'(fpIf.in_ready),  64'd1);
        checkOutput("rst_out_valid", 64'(fpIf.out_valid), 64'd0);
        checkOutput("rst_out_data",  64'(fpIf.out_data),  64'd0);
        checkOutput("rst_out_len",   64'(fpIf.out_len),   64'd0);
        checkOutput("rst_out_ovf",   64'(fpIf.out_ovf),   64'd0);
        checkOutput("rst_fma_a",     64'(fpIf.fma_a),     64'd0);
        checkOutput("rst_fma_c",     64'(fpIf.fma_c),     64'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        $display("[TB] asynchronous reset during EXEC");
        applyStimulus(32'h3F800000, 32'h40000000, 1'b0);
        cyc();
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b0);
        checkOutput("pre_rst_fma_c", 64'(fpIf.fma_c), 64'h40000000);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_in_ready",  64'(fpIf.in_ready),  64'd1);
        checkOutput("async_rst_out_valid", 64'(fpIf.out_valid), 64'd0);
        checkOutput("async_rst_fma_c",     64'(fpIf.fma_c),     64'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        $display("[TB] two-element vector");
        applyStimulus(32'h3F800000, 32'h40000000, 1'b0);
        checkOutput("exec1_fma_a",    64'(fpIf.fma_a),    64'h3F800000);
        checkOutput("exec1_fma_b",    64'(fpIf.fma_b),    64'h40000000);
        checkOutput("exec1_fma_c",    64'(fpIf.fma_c),    64'h0);
        checkOutput("exec1_in_ready", 64'(fpIf.in_ready), 64'd0);
        cyc();
        checkOutput("accept2_in_ready", 64'(fpIf.in_ready), 64'd1);
        fpQ.push_back('{data: 32'h40A00000, len: 9'd2, ovf: 1'b0});
        applyStimulus(32'h40400000, 32'h3F800000, 1'b1);
        checkOutput("exec2_fma_c",     64'(fpIf.fma_c),     64'h40000000);
        checkOutput("exec2_out_valid", 64'(fpIf.out_valid), 64'd0);
        cyc();
        checkOutput("latency_out_valid", 64'(fpIf.out_valid), 64'd1);
        fpResult("vec2");

        $display("[TB] backpressure in DONE");
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", 64'(fpIf.out_valid), 64'd1);
            checkOutput("bp_out_data",  64'(fpIf.out_data),  64'h40A00000);
            checkOutput("bp_out_len",   64'(fpIf.out_len),   64'd2);
            checkOutput("bp_in_ready",  64'(fpIf.in_ready),  64'd0);
            cyc();
        end
        fpIf.out_ready = 1'b1;
        cyc();
        fpIf.out_ready = 1'b0;
        checkOutput("bp_release_in_ready",  64'(fpIf.in_ready),  64'd1);
        checkOutput("bp_release_out_valid", 64'(fpIf.out_valid), 64'd0);
        checkOutput("bp_release_fma_c",     64'(fpIf.fma_c),     64'h0);

        $display("[TB] clear during EXEC and ACCEPT");
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b0);
        cyc();
        applyStimulus(32'h40000000, 32'h3F800000, 1'b0);
        fpIf.in_valid = 1'b1;
        fpIf.in_a     = 32'h40400000;
        fpIf.in_b     = 32'h40400000;
        fpIf.in_last  = 1'b1;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        checkOutput("clr_exec_fma_c",     64'(fpIf.fma_c),     64'h0);
        checkOutput("clr_exec_out_len",   64'(fpIf.out_len),   64'd0);
        checkOutput("clr_exec_in_ready",  64'(fpIf.in_ready),  64'd1);
        checkOutput("clr_exec_out_valid", 64'(fpIf.out_valid), 64'd0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        fpIf.in_valid = 1'b0;
        checkOutput("clr_accept_in_ready", 64'(fpIf.in_ready), 64'd1);
        checkOutput("clr_accept_out_len",  64'(fpIf.out_len),  64'd0);
        fpQ.push_back('{data: 32'h3F800000, len: 9'd1, ovf: 1'b0});
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b1);
        cyc();
        fpResult("single");
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        checkOutput("clr_done_out_valid", 64'(fpIf.out_valid), 64'd0);
        checkOutput("clr_done_in_ready",  64'(fpIf.in_ready),  64'd1);
        checkOutput("clr_done_fma_c",     64'(fpIf.fma_c),     64'h0);

        $display("[TB] MAX_LEN termination");
        intIf.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) applyInt(32'd1, 32'd1, 1'b0);
        applyInt(32'd1, 32'd1, 1'b1);
        drainInt("ovf_drain");
        for (int i = 0; i < 4; i++) applyInt(32'd1, 32'd1, i == 3);
        drainInt("last_at_limit_drain");

        $display("[TB] random handshake stream");
        fork
            begin
                for (int v = 0; v < 1000; v++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int e = 0; e < len; e++) begin
                        int gap;
                        gap = $urandom_range(0, 2);
                        for (int g = 0; g < gap; g++) cyc();
                        applyInt(32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), e == len - 1);
                    end
                end
                drvDone = 1'b1;
            end
            begin
                while (!drvDone) begin
                    intIf.out_ready = 1'($urandom_range(0, 1));
                    cyc();
                end
                intIf.out_ready = 1'b1;
            end
        join
        drainInt("random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
